sram_2port_arb: RTL and testbench

//  Word-organised on-chip SRAM model shared by the instruction-fetch (IF) and load/store (LS) ports.

---
 rtl/sram_pkg.sv | 39 +++
 rtl/sram_lane_fmt.sv | 55 +++++
 rtl/sram_2port_arb.sv | 201 ++++++++++++++++++++
 tb/tb_sram_2port_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and address checking for the two-port arbitrated SRAM.
package sram_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef enum logic {
    P_IF = 1'b0,
    P_LS = 1'b1
  } port_e;

  // Out of the array window, misaligned for the access size, or an illegal size.
  function automatic logic addr_err(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] span,
                                    input size_e       size);
    logic oor;
    logic mis;
    oor = (addr < base) || ((addr - base) >= span);
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr[0];
      SZ_W:    mis = |addr[1:0];
      default: mis = 1'b1;
    endcase
    return oor | mis;
  endfunction

endpackage

// File: rtl/sram_lane_fmt.sv
// Byte-lane steering: store enables/replication and load extraction/extension.
module sram_lane_fmt
  import sram_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be    = 4'b0000;
    wword = 32'h0000_0000;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << off;
        wword = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      SZ_W: begin
        be    = 4'b1111;
        wword = wdata;
      end
      default: begin
        be    = 4'b0000;
        wword = 32'h0000_0000;
      end
    endcase
  end

  // Load lane selection followed by sign or zero extension.
  always_comb begin
    byte_s = rword[{off, 3'b000} +: 8];
    half_s = off[1] ? rword[31:16] : rword[15:0];
    rdata  = 32'h0000_0000;
    case (size)
      SZ_B:    rdata = uns ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
      SZ_H:    rdata = uns ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      SZ_W:    rdata = rword;
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/sram_2port_arb.sv
// Word SRAM shared by fetch and load/store ports; round-robin, one transaction in flight,
// programmable latency, sized loads/stores with error reporting.
module sram_2port_arb
  import sram_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned           DEPTH_WORDS = 64,
  parameter int unsigned           LATENCY     = 1,
  parameter string                 INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_resp_valid,
  input  logic                  if_resp_ready,
  output logic [31:0]           if_resp_data,
  output logic                  if_resp_err,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_WIDTH-1:0] ls_req_addr,
  input  logic                  ls_req_we,
  input  logic [1:0]            ls_req_size,
  input  logic                  ls_req_unsigned,
  input  logic [31:0]           ls_req_wdata,
  output logic                  ls_resp_valid,
  input  logic                  ls_resp_ready,
  output logic [31:0]           ls_resp_rdata,
  output logic                  ls_resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1) + 1;
  localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) * 64'd4;

  logic [31:0] mem_r [DEPTH_WORDS];

  state_e          state_r;
  logic [CNT_W-1:0] cnt_r;
  port_e           last_grant_r;
  port_e           port_r;
  logic [IDX_W-1:0] idx_r;
  logic [1:0]      off_r;
  size_e           size_r;
  logic            uns_r;
  logic            we_r;
  logic            err_r;
  logic [31:0]     wdata_r;

  logic                  gnt_ls_s;
  logic                  acc_s;
  logic                  done_s;
  logic                  wr_en_s;
  logic                  resp_hs_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [ADDR_WIDTH-1:0] sel_off_s;
  size_e                 sel_size_s;
  logic                  sel_err_s;
  logic [3:0]            be_s;
  logic [31:0]           wword_s;
  logic [31:0]           rword_s;
  logic [31:0]           rfmt_s;

  // Round-robin grant: a sole requester wins, a tie goes to the port not granted last.
  always_comb begin
    gnt_ls_s = 1'b0;
    if (if_req_valid && ls_req_valid) begin
      gnt_ls_s = (last_grant_r == P_IF);
    end else if (ls_req_valid) begin
      gnt_ls_s = 1'b1;
    end else begin
      gnt_ls_s = 1'b0;
    end
  end

  // Request fields of the granted port and their address check.
  always_comb begin
    sel_addr_s = gnt_ls_s ? ls_req_addr : if_req_addr;
    sel_size_s = gnt_ls_s ? size_e'(ls_req_size) : SZ_W;
    sel_off_s  = sel_addr_s - BASE_ADDR;
    sel_err_s  = addr_err(64'(sel_addr_s), 64'(BASE_ADDR), SPAN, sel_size_s);
  end

  // Ready is offered only in IDLE and only to the granted port.
  always_comb begin
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    if (!rst && (state_r == IDLE)) begin
      if_req_ready = if_req_valid && !gnt_ls_s;
      ls_req_ready = ls_req_valid && gnt_ls_s;
    end else begin
      if_req_ready = 1'b0;
      ls_req_ready = 1'b0;
    end
  end

  assign acc_s     = (state_r == IDLE) && (if_req_valid || ls_req_valid);
  assign done_s    = (state_r == BUSY) && (cnt_r == CNT_W'(LATENCY));
  assign wr_en_s   = done_s && we_r && !err_r && !rst;
  assign resp_hs_s = (port_r == P_LS) ? (ls_resp_valid && ls_resp_ready)
                                      : (if_resp_valid && if_resp_ready);
  assign rword_s   = mem_r[idx_r];

  sram_lane_fmt u_lane_fmt (
    .size  (size_r),
    .uns   (uns_r),
    .off   (off_r),
    .wdata (wdata_r),
    .rword (rword_s),
    .be    (be_s),
    .wword (wword_s),
    .rdata (rfmt_s)
  );

  // Byte-masked array write on the cycle the access completes; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_r[idx_r][8*b +: 8] <= wword_s[8*b +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      last_grant_r  <= P_LS;
      port_r        <= P_IF;
      idx_r         <= '0;
      off_r         <= 2'b00;
      size_r        <= SZ_W;
      uns_r         <= 1'b0;
      we_r          <= 1'b0;
      err_r         <= 1'b0;
      wdata_r       <= 32'h0000_0000;
      if_resp_valid <= 1'b0;
      if_resp_data  <= 32'h0000_0000;
      if_resp_err   <= 1'b0;
      ls_resp_valid <= 1'b0;
      ls_resp_rdata <= 32'h0000_0000;
      ls_resp_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (acc_s) begin
            port_r       <= gnt_ls_s ? P_LS : P_IF;
            last_grant_r <= gnt_ls_s ? P_LS : P_IF;
            idx_r        <= IDX_W'(sel_off_s >> 2);
            off_r        <= sel_addr_s[1:0];
            size_r       <= sel_size_s;
            uns_r        <= gnt_ls_s && ls_req_unsigned;
            we_r         <= gnt_ls_s && ls_req_we;
            err_r        <= sel_err_s;
            wdata_r      <= ls_req_wdata;
            cnt_r        <= CNT_W'(1);
            state_r      <= BUSY;
          end
        end
        BUSY: begin
          if (done_s) begin
            state_r <= RESP;
            if (port_r == P_LS) begin
              ls_resp_valid <= 1'b1;
              ls_resp_rdata <= (err_r || we_r) ? 32'h0000_0000 : rfmt_s;
              ls_resp_err   <= err_r;
            end else begin
              if_resp_valid <= 1'b1;
              if_resp_data  <= err_r ? 32'h0000_0000 : rword_s;
              if_resp_err   <= err_r;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_hs_s) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= 32'h0000_0000;
            if_resp_err   <= 1'b0;
            ls_resp_valid <= 1'b0;
            ls_resp_rdata <= 32'h0000_0000;
            ls_resp_err   <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_2port_arb.sv
// Directed bench: one instance at LATENCY=1, a second at LATENCY=3 for the stall test.
module tb_sram_2port_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        use3;
  logic        t_req_valid, t_we, t_uns, t_resp_ready;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata;
  logic        if_req_valid, if_resp_ready;
  logic [31:0] if_req_addr;

  logic        if_req_ready1, if_resp_valid1, if_resp_err1;
  logic [31:0] if_resp_data1;
  logic        ls_req_ready1, ls_resp_valid1, ls_resp_err1;
  logic [31:0] ls_resp_rdata1;
  logic        if_req_ready3, if_resp_valid3, if_resp_err3;
  logic [31:0] if_resp_data3;
  logic        ls_req_ready3, ls_resp_valid3, ls_resp_err3;
  logic [31:0] ls_resp_rdata3;

  logic        ls1_valid, ls1_resp_ready, ls3_valid, ls3_resp_ready;
  logic        t_req_ready, t_resp_valid, t_resp_err;
  logic [31:0] t_resp_rdata;

  assign ls1_valid      = use3 ? 1'b0 : t_req_valid;
  assign ls1_resp_ready = use3 ? 1'b0 : t_resp_ready;
  assign ls3_valid      = use3 ? t_req_valid : 1'b0;
  assign ls3_resp_ready = use3 ? t_resp_ready : 1'b0;
  assign t_req_ready    = use3 ? ls_req_ready3 : ls_req_ready1;
  assign t_resp_valid   = use3 ? ls_resp_valid3 : ls_resp_valid1;
  assign t_resp_err     = use3 ? ls_resp_err3 : ls_resp_err1;
  assign t_resp_rdata   = use3 ? ls_resp_rdata3 : ls_resp_rdata1;

  sram_2port_arb #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready1), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid1), .if_resp_ready(if_resp_ready), .if_resp_data(if_resp_data1),
    .if_resp_err(if_resp_err1),
    .ls_req_valid(ls1_valid), .ls_req_ready(ls_req_ready1), .ls_req_addr(t_addr),
    .ls_req_we(t_we), .ls_req_size(t_size), .ls_req_unsigned(t_uns), .ls_req_wdata(t_wdata),
    .ls_resp_valid(ls_resp_valid1), .ls_resp_ready(ls1_resp_ready), .ls_resp_rdata(ls_resp_rdata1),
    .ls_resp_err(ls_resp_err1)
  );

  sram_2port_arb #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req_valid(1'b0), .if_req_ready(if_req_ready3), .if_req_addr(32'h0000_0000),
    .if_resp_valid(if_resp_valid3), .if_resp_ready(1'b0), .if_resp_data(if_resp_data3),
    .if_resp_err(if_resp_err3),
    .ls_req_valid(ls3_valid), .ls_req_ready(ls_req_ready3), .ls_req_addr(t_addr),
    .ls_req_we(t_we), .ls_req_size(t_size), .ls_req_unsigned(t_uns), .ls_req_wdata(t_wdata),
    .ls_resp_valid(ls_resp_valid3), .ls_resp_ready(ls3_resp_ready), .ls_resp_rdata(ls_resp_rdata3),
    .ls_resp_err(ls_resp_err3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One LS transaction on the selected instance; called and returns at a falling edge.
  task automatic ls_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    int n;
    t_req_valid = 1'b1; t_we = we; t_size = size; t_uns = uns; t_addr = addr; t_wdata = wdata;
    #1; n = 0;
    while (!t_req_ready && n < 20) begin @(negedge clk); #1; n++; end
    chk("req_ready", 32'(t_req_ready), 32'd1);
    @(negedge clk);
    t_req_valid = 1'b0;
    #1; lat = 0;
    while (!t_resp_valid && lat < 20) begin @(negedge clk); #1; lat++; end
    chk("resp_valid", 32'(t_resp_valid), 32'd1);
    rdata = t_resp_rdata; err = t_resp_err;
    t_resp_ready = 1'b1;
    @(negedge clk);
    t_resp_ready = 1'b0;
  endtask

  task automatic st(input string tag, input logic [1:0] size, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic exp_err);
    logic [31:0] rd; logic er; int lat;
    ls_op(1'b1, size, 1'b0, addr, wdata, rd, er, lat);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_rdata"}, rd, 32'h0000_0000);
    chk({tag, "_lat"}, 32'(lat), use3 ? 32'd3 : 32'd1);
  endtask

  task automatic ld(input string tag, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                    input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd; logic er; int lat;
    ls_op(1'b0, size, uns, addr, 32'h0000_0000, rd, er, lat);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_rdata"}, rd, exp_data);
    chk({tag, "_lat"}, 32'(lat), use3 ? 32'd3 : 32'd1);
  endtask

  task automatic if_fetch(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic exp_err);
    int n; int lat;
    if_req_valid = 1'b1; if_req_addr = addr;
    #1; n = 0;
    while (!if_req_ready1 && n < 20) begin @(negedge clk); #1; n++; end
    chk({tag, "_ready"}, 32'(if_req_ready1), 32'd1);
    @(negedge clk);
    if_req_valid = 1'b0;
    #1; lat = 0;
    while (!if_resp_valid1 && lat < 20) begin @(negedge clk); #1; lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_err"}, 32'(if_resp_err1), 32'(exp_err));
    chk({tag, "_data"}, if_resp_data1, exp_data);
    if_resp_ready = 1'b1;
    @(negedge clk);
    if_resp_ready = 1'b0;
  endtask

  int lat;
  int g;
  int n;

  initial begin
    rst = 1'b1; use3 = 1'b0;
    t_req_valid = 1'b1; t_we = 1'b0; t_uns = 1'b0; t_size = 2'b10; t_resp_ready = 1'b0;
    t_addr = 32'h8000_0000; t_wdata = 32'h0000_0000;
    if_req_valid = 1'b1; if_resp_ready = 1'b0; if_req_addr = 32'h8000_0000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_if_ready", 32'(if_req_ready1), 32'd0);
    chk("rst_ls_ready", 32'(ls_req_ready1), 32'd0);
    chk("rst_ls_valid", 32'(ls_resp_valid1), 32'd0);
    chk("rst_if_valid", 32'(if_resp_valid1), 32'd0);
    chk("rst_rdata", ls_resp_rdata1, 32'h0000_0000);
    t_req_valid = 1'b0; if_req_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // T1: word store then load
    st("t1_st", 2'b10, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
    ld("t1_ld", 2'b10, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
    if_fetch("if_ok", 32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
    if_fetch("if_mis", 32'h8000_0006, 32'h0000_0000, 1'b1);

    // T2: sub-word stores and extended loads
    st("t2_stw", 2'b10, 32'h8000_0008, 32'h1122_3344, 1'b0);
    st("t2_stb", 2'b00, 32'h8000_0009, 32'h1234_5680, 1'b0);
    ld("t2_lbs", 2'b00, 1'b0, 32'h8000_0009, 32'hFFFF_FF80, 1'b0);
    ld("t2_lbu", 2'b00, 1'b1, 32'h8000_0009, 32'h0000_0080, 1'b0);
    ld("t2_lhs", 2'b01, 1'b0, 32'h8000_0008, 32'hFFFF_8044, 1'b0);
    ld("t2_lhu", 2'b01, 1'b1, 32'h8000_000A, 32'h0000_1122, 1'b0);
    ld("t2_lw", 2'b10, 1'b0, 32'h8000_0008, 32'h1122_8044, 1'b0);
    st("t2_sth", 2'b01, 32'h8000_000A, 32'hBEEF_7FFE, 1'b0);
    ld("t2_lhs2", 2'b01, 1'b0, 32'h8000_000A, 32'h0000_7FFE, 1'b0);
    ld("t2_lbs3", 2'b00, 1'b0, 32'h8000_000B, 32'h0000_007F, 1'b0);

    // T4: error cases leave memory untouched
    ld("t4_mis", 2'b01, 1'b0, 32'h8000_0003, 32'h0000_0000, 1'b1);
    st("t4_top", 2'b10, 32'h8000_00FC, 32'hCAFE_F00D, 1'b0);
    st("t4_low", 2'b10, 32'h7FFF_FFFC, 32'h0000_0000, 1'b1);
    ld("t4_keep", 2'b10, 1'b0, 32'h8000_00FC, 32'hCAFE_F00D, 1'b0);
    ld("t4_high", 2'b10, 1'b0, 32'h8000_0100, 32'h0000_0000, 1'b1);
    ld("t4_sz3", 2'b11, 1'b0, 32'h8000_0008, 32'h0000_0000, 1'b1);
    st("t4_sth_mis", 2'b01, 32'h8000_0009, 32'h0000_0000, 1'b1);
    ld("t4_keep2", 2'b10, 1'b0, 32'h8000_0008, 32'h7FFE_8044, 1'b0);

    // T3: both ports requesting continuously alternate IF, LS, IF, LS
    if_req_addr = 32'h8000_0004; t_we = 1'b0; t_size = 2'b10; t_addr = 32'h8000_0004;
    if_resp_ready = 1'b1; t_resp_ready = 1'b1; if_req_valid = 1'b1; t_req_valid = 1'b1;
    g = 0; n = 0;
    while (g < 4 && n < 60) begin
      #1;
      if (if_req_ready1 || ls_req_ready1) begin
        chk($sformatf("t3_grant%0d", g), 32'({if_req_ready1, ls_req_ready1}),
            (g % 2 == 1) ? 32'd1 : 32'd2);
        g++;
        if (g == 4) begin
          @(negedge clk);
          if_req_valid = 1'b0; t_req_valid = 1'b0;
        end
      end
      @(negedge clk);
      n++;
    end
    chk("t3_count", 32'(g), 32'd4);
    repeat (4) @(negedge clk);
    if_resp_ready = 1'b0; t_resp_ready = 1'b0;

    // T6: reset during a store's BUSY cancels it
    t_we = 1'b1; t_size = 2'b10; t_uns = 1'b0; t_addr = 32'h8000_0004; t_wdata = 32'h5555_5555;
    t_req_valid = 1'b1;
    #1 chk("t6_ready", 32'(ls_req_ready1), 32'd1);
    @(negedge clk);
    t_req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      #1 chk("t6_no_resp", 32'(ls_resp_valid1), 32'd0);
      @(negedge clk);
    end
    ld("t6_old", 2'b10, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0);

    // T5: LATENCY=3 instance, response held while consumer stalls
    use3 = 1'b1;
    @(negedge clk);
    st("t5_st", 2'b10, 32'h8000_0010, 32'hA5A5_5A5A, 1'b0);
    t_we = 1'b0; t_size = 2'b10; t_uns = 1'b0; t_addr = 32'h8000_0010; t_req_valid = 1'b1;
    #1 chk("t5_ready", 32'(t_req_ready), 32'd1);
    @(negedge clk);
    t_req_valid = 1'b0;
    #1; lat = 0;
    while (!t_resp_valid && lat < 20) begin @(negedge clk); #1; lat++; end
    chk("t5_lat", 32'(lat), 32'd3);
    t_req_valid = 1'b1; t_addr = 32'h8000_0014;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t5_hold_valid", 32'(t_resp_valid), 32'd1);
      chk("t5_hold_data", t_resp_rdata, 32'hA5A5_5A5A);
      chk("t5_hold_ready", 32'(t_req_ready), 32'd0);
      @(negedge clk);
    end
    t_req_valid = 1'b0; t_resp_ready = 1'b1;
    @(negedge clk);
    t_resp_ready = 1'b0;
    #1 chk("t5_released", 32'(t_resp_valid), 32'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
